// File: rtl/computation_layer_ctrl.sv
// computation_layer_ctrl: sequences nIters launches of a downstream layer.
// Each iteration issues a one-cycle en pulse, waits one settle cycle, then
// waits for layer_ready before the next launch. A done pulse follows the
// final iteration.
// Optional feature macro: COMPUTATION_LAYER_CTRL_TIMEOUT_EN adds a WAIT
// timeout that raises a sticky err flag and abandons the evaluation.
module computation_layer_ctrl #(
  parameter int nIters     = 1,
  parameter int nCountBits = 1,
  parameter int tmo_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  layer_ready,
  output logic                  en,
  output logic [nCountBits-1:0] count_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = nCountBits;
  localparam logic [CW-1:0] LAST_CNT = CW'(nIters - 1);

  // Reject parameterisations the counter or timeout cannot represent
  generate
    if ((2 ** nCountBits) < nIters) begin : g_bad_count_width
      $error("computation_layer_ctrl: nCountBits too small for nIters");
    end
    if (nIters < 1) begin : g_bad_iters
      $error("computation_layer_ctrl: nIters must be >= 1");
    end
    if (tmo_cycles < 1) begin : g_bad_tmo
      $error("computation_layer_ctrl: tmo_cycles must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRE   = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept_c;
  logic          tmo_hit_c;

  assign accept_c = (state_q == S_IDLE) && start && layer_ready;

`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (tmo_cycles > 1) ? $clog2(tmo_cycles + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(tmo_cycles - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Timeout detect: the stalled WAIT cycle that completes tmo_cycles
  assign tmo_hit_c = (state_q == S_WAIT) && !layer_ready && (tmo_q == TMO_LAST);

  // Stall counter: cleared on entry to WAIT, counts WAIT cycles without ready
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_SETTLE) begin
      tmo_d = '0;
    end else if ((state_q == S_WAIT) && !layer_ready && !tmo_hit_c) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (layer_ready) begin
          state_d = (count_q == LAST_CNT) ? S_DONE : S_FIRE;
        end else if (tmo_hit_c) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values, decoded from the upcoming state so every
  // output is a flop that lines up with the state it belongs to
  always_comb begin
    count_d = count_q;
    en_d    = (state_d == S_FIRE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = 1'b0;
`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
    err_d   = err_q;
    if (accept_c) begin
      err_d = 1'b0;
    end else if (tmo_hit_c) begin
      err_d = 1'b1;
    end
`endif
    if (accept_c) begin
      count_d = '0;
    end else if ((state_q == S_WAIT) && layer_ready && (count_q != LAST_CNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Output and iteration-count registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      count_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign en        = en_q;
  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
